// File: rtl/mem_rd_arbiter.sv
// Round-robin arbiter that shares one AXI read port between the icache and dcache fill paths.
// AR issues 1 cycle after a request in IDLE; R beats steer combinationally; rready only in DATA, arvalid held until arready.
module mem_rd_arbiter #(
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int BURST_LEN  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ic_req_valid,
    input  logic [ADDR_WIDTH-1:0] ic_req_addr,
    output logic                  ic_req_ready,
    output logic                  ic_rvalid,
    output logic                  ic_rlast,
    input  logic                  dc_req_valid,
    input  logic [ADDR_WIDTH-1:0] dc_req_addr,
    output logic                  dc_req_ready,
    output logic                  dc_rvalid,
    output logic                  dc_rlast,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic                  bus_err
);

    localparam int                CNT_W     = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(BURST_LEN);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t                 state, state_nxt;
    logic                   grant, grant_nxt;   // 0 = icache, 1 = dcache
    logic                   last_grant;
    logic [ADDR_WIDTH-1:0]  araddr_q;
    logic [CNT_W-1:0]       beat_cnt;
    logic                   bus_err_q;
    logic                   beat;
    logic                   beat_err;

    assign m_axi_arid    = ID_WIDTH'(grant);
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = 8'(BURST_LEN - 1);
    assign m_axi_arsize  = 3'($clog2(DATA_WIDTH / 8));
    assign m_axi_arburst = 2'b01;
    assign rdata         = m_axi_rdata;
    assign bus_err       = bus_err_q;

    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        ic_req_ready  = 1'b0;
        dc_req_ready  = 1'b0;
        ic_rvalid     = 1'b0;
        dc_rvalid     = 1'b0;
        ic_rlast      = 1'b0;
        dc_rlast      = 1'b0;
        beat          = 1'b0;
        beat_err      = 1'b0;
        case (state)
            IDLE: begin
                if (ic_req_valid || dc_req_valid) begin
                    // On a tie the requester not served last wins.
                    grant_nxt = (ic_req_valid && dc_req_valid) ? ~last_grant : dc_req_valid;
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) begin
                    ic_req_ready = ~grant;
                    dc_req_ready = grant;
                    state_nxt    = DATA;
                end
            end
            DATA: begin
                m_axi_rready = 1'b1;
                beat         = m_axi_rvalid;
                ic_rvalid    = beat & ~grant;
                dc_rvalid    = beat & grant;
                ic_rlast     = beat & m_axi_rlast & ~grant;
                dc_rlast     = beat & m_axi_rlast & grant;
                // A beat at LAST_BEAT without rlast means the burst overran its length.
                beat_err     = beat & ((m_axi_rresp != 2'b00) || (m_axi_rid != m_axi_arid) ||
                                       (m_axi_rlast && beat_cnt != LAST_BEAT) ||
                                       (!m_axi_rlast && beat_cnt >= LAST_BEAT));
                if (beat && m_axi_rlast) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b0;
            araddr_q   <= '0;
            beat_cnt   <= '0;
            bus_err_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            if (state == IDLE && (ic_req_valid || dc_req_valid)) begin
                araddr_q <= grant_nxt ? dc_req_addr : ic_req_addr;
            end
            if (state == ADDR && m_axi_arready) begin
                last_grant <= grant;
                beat_cnt   <= '0;
            end else if (beat && beat_cnt != CNT_MAX) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (beat_err) begin
                bus_err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Scoreboard bench for mem_rd_arbiter: directed fills, arbitration, backpressure, errors and reset.
module tb_mem_rd_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        ic_req_valid, dc_req_valid;
    logic [63:0] ic_req_addr, dc_req_addr;
    logic        ic_req_ready, dc_req_ready;
    logic        ic_rvalid, dc_rvalid, ic_rlast, dc_rlast;
    logic [63:0] rdata;
    logic [12:0] m_axi_arid;
    logic [63:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arvalid, m_axi_arready;
    logic [12:0] m_axi_rid;
    logic [63:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;
    logic        bus_err;

    always #5 clk = ~clk;

    mem_rd_arbiter dut (
        .clk(clk), .reset(reset),
        .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
        .ic_rvalid(ic_rvalid), .ic_rlast(ic_rlast),
        .dc_req_valid(dc_req_valid), .dc_req_addr(dc_req_addr), .dc_req_ready(dc_req_ready),
        .dc_rvalid(dc_rvalid), .dc_rlast(dc_rlast),
        .rdata(rdata),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .bus_err(bus_err)
    );

    typedef struct { logic [12:0] id; logic [63:0] addr; } ar_t;
    typedef struct { logic dc; logic [63:0] data; logic last; } beat_t;

    ar_t   exp_ar[$];
    beat_t exp_beat[$];
    int    n_cmp = 0;
    int    n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an AR handshake or a requester beat.
    always @(negedge clk) begin
        ar_t   a;
        beat_t b;
        if (m_axi_arvalid && m_axi_arready) begin
            check("ar_pending", exp_ar.size() != 0, 1);
            if (exp_ar.size() != 0) begin
                a = exp_ar.pop_front();
                check("arid", m_axi_arid, a.id);
                check("araddr", m_axi_araddr, a.addr);
                check("arlen", m_axi_arlen, 7);
                check("arsize", m_axi_arsize, 3);
                check("arburst", m_axi_arburst, 1);
                check("ic_req_ready", ic_req_ready, a.id == 0);
                check("dc_req_ready", dc_req_ready, a.id == 1);
            end
        end else if (m_axi_arvalid && exp_ar.size() != 0) begin
            check("stall_araddr", m_axi_araddr, exp_ar[0].addr);
            check("stall_arid", m_axi_arid, exp_ar[0].id);
        end
        if (ic_req_ready || dc_req_ready)
            check("req_ready_needs_ar_hs", m_axi_arvalid && m_axi_arready, 1);
        if (ic_rvalid || dc_rvalid) begin
            check("rvalid_exclusive", ic_rvalid && dc_rvalid, 0);
            check("beat_pending", exp_beat.size() != 0, 1);
            if (exp_beat.size() != 0) begin
                b = exp_beat.pop_front();
                check("dc_rvalid", dc_rvalid, b.dc);
                check("rdata", rdata, b.data);
                check("ic_rlast", ic_rlast, b.last && !b.dc);
                check("dc_rlast", dc_rlast, b.last && b.dc);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        ic_req_valid = 0; dc_req_valid = 0; m_axi_arready = 0;
        m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_rresp = 0; m_axi_rid = 0;
        reset = 0;
        step; step;
        reset = 1;
    endtask

    task automatic push_ar(input logic [12:0] id, input logic [63:0] addr);
        ar_t a;
        a.id = id; a.addr = addr;
        exp_ar.push_back(a);
    endtask

    task automatic push_beats(input logic dc, input logic [63:0] base, input int n, input int last_at);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.dc = dc; b.data = base + 64'(i); b.last = (i == last_at);
            exp_beat.push_back(b);
        end
    endtask

    task automatic wait_arvalid(output int lat);
        lat = 0;
        while (!m_axi_arvalid && lat < 20) begin
            step;
            lat++;
        end
        check("arvalid_seen", m_axi_arvalid, 1);
    endtask

    task automatic ar_hs(input int delay);
        int lat;
        wait_arvalid(lat);
        repeat (delay) step;
        m_axi_arready = 1;
        step;
        m_axi_arready = 0;
    endtask

    task automatic r_burst(input logic [12:0] rid, input int n, input int last_at,
                           input int resp_at, input logic [1:0] resp, input logic [63:0] base);
        for (int i = 0; i < n; i++) begin
            check("rready_in_data", m_axi_rready, 1);
            check("no_ar_in_data", m_axi_arvalid, 0);
            m_axi_rvalid = 1;
            m_axi_rdata  = base + 64'(i);
            m_axi_rid    = rid;
            m_axi_rresp  = (i == resp_at) ? resp : 2'b00;
            m_axi_rlast  = (i == last_at);
            step;
        end
        m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_rresp = 0;
    endtask

    task automatic ic_fill(input logic [63:0] addr, input logic [63:0] base);
        push_ar(0, addr);
        push_beats(0, base, 8, 7);
        ic_req_addr = addr; ic_req_valid = 1;
        ar_hs(0);
        ic_req_valid = 0;
        r_burst(0, 8, 7, -1, 2'b00, base);
    endtask

    task automatic err_case(input int n, input int last_at, input int resp_at,
                            input logic [1:0] resp, input logic [12:0] rid);
        do_reset;
        push_ar(0, 64'h6000);
        push_beats(0, 64'h600, n, last_at);
        ic_req_addr = 64'h6000; ic_req_valid = 1;
        ar_hs(0);
        ic_req_valid = 0;
        check("err_clear_before", bus_err, 0);
        r_burst(rid, n, last_at, resp_at, resp, 64'h600);
        check("err_set", bus_err, 1);
        check("err_idle_rready", m_axi_rready, 0);
        check("err_idle_arvalid", m_axi_arvalid, 0);
        step; step;
        check("err_sticky", bus_err, 1);
    endtask

    initial begin
        int lat;
        ic_req_addr = 0; dc_req_addr = 0; m_axi_rdata = 0;
        do_reset;
        reset = 0;
        step;
        check("rst_arvalid", m_axi_arvalid, 0);
        check("rst_rready", m_axi_rready, 0);
        check("rst_req_ready", {ic_req_ready, dc_req_ready}, 0);
        check("rst_rvalid", {ic_rvalid, dc_rvalid}, 0);
        check("rst_rlast", {ic_rlast, dc_rlast}, 0);
        check("rst_araddr", m_axi_araddr, 0);
        check("rst_arid", m_axi_arid, 0);
        check("rst_bus_err", bus_err, 0);
        reset = 1;
        step;

        // Single icache fill, AR one cycle after request
        push_ar(0, 64'h1000);
        push_beats(0, 64'h0, 8, 7);
        ic_req_addr = 64'h1000; ic_req_valid = 1;
        wait_arvalid(lat);
        check("ar_latency", lat, 1);
        m_axi_arready = 1;
        step;
        m_axi_arready = 0; ic_req_valid = 0;
        r_burst(0, 8, 7, -1, 2'b00, 64'h0);
        check("fill_bus_err", bus_err, 0);

        // Tie after reset: dcache first, then icache two cycles after rlast
        do_reset;
        push_ar(1, 64'h3000); push_ar(0, 64'h2000);
        push_beats(1, 64'h300, 8, 7); push_beats(0, 64'h200, 8, 7);
        ic_req_addr = 64'h2000; dc_req_addr = 64'h3000;
        ic_req_valid = 1; dc_req_valid = 1;
        ar_hs(0);
        dc_req_valid = 0;
        r_burst(1, 8, 7, -1, 2'b00, 64'h300);
        check("b2b_gap", m_axi_arvalid, 0);
        step;
        check("b2b_arvalid", m_axi_arvalid, 1);
        ar_hs(0);
        ic_req_valid = 0;
        r_burst(0, 8, 7, -1, 2'b00, 64'h200);

        // Round-robin with both held: dc, ic, dc, ic
        for (int k = 0; k < 4; k++) begin
            push_ar((k % 2 == 0) ? 13'd1 : 13'd0, (k % 2 == 0) ? 64'h3000 : 64'h2000);
            push_beats(k % 2 == 0, 64'h1000 + 64'(k * 16), 8, 7);
        end
        ic_req_valid = 1; dc_req_valid = 1;
        for (int k = 0; k < 4; k++) begin
            ar_hs(0);
            r_burst((k % 2 == 0) ? 13'd1 : 13'd0, 8, 7, -1, 2'b00, 64'h1000 + 64'(k * 16));
        end
        ic_req_valid = 0; dc_req_valid = 0;

        // Backpressure on AR, plus a dcache request arriving during DATA
        push_ar(0, 64'h4000);
        push_beats(0, 64'h400, 8, 7);
        ic_req_addr = 64'h4000; ic_req_valid = 1;
        ar_hs(5);
        ic_req_valid = 0;
        push_ar(1, 64'h5000);
        push_beats(1, 64'h500, 8, 7);
        dc_req_addr = 64'h5000; dc_req_valid = 1;
        r_burst(0, 8, 7, -1, 2'b00, 64'h400);
        check("late_req_gap", m_axi_arvalid, 0);
        step;
        check("late_req_arvalid", m_axi_arvalid, 1);
        ar_hs(0);
        dc_req_valid = 0;
        r_burst(1, 8, 7, -1, 2'b00, 64'h500);
        check("clean_bus_err", bus_err, 0);

        // Error cases: bad rresp, early rlast, wrong rid, overlong burst
        err_case(8, 7, 3, 2'b10, 13'd0);
        err_case(6, 5, -1, 2'b00, 13'd0);
        err_case(8, 7, -1, 2'b00, 13'd1);
        err_case(9, 8, -1, 2'b00, 13'd0);
        ic_fill(64'h6100, 64'h610);
        check("err_sticky_after_clean", bus_err, 1);

        // Reset during beat 4 with an error already latched
        do_reset;
        push_ar(0, 64'h7000);
        push_beats(0, 64'h700, 5, -1);
        ic_req_addr = 64'h7000; ic_req_valid = 1;
        ar_hs(0);
        ic_req_valid = 0;
        r_burst(0, 4, -1, 1, 2'b10, 64'h700);
        check("mid_err_set", bus_err, 1);
        reset = 0;
        m_axi_rvalid = 1; m_axi_rdata = 64'h704; m_axi_rid = 0; m_axi_rlast = 0;
        step;
        m_axi_rvalid = 0;
        check("mid_rst_rready", m_axi_rready, 0);
        check("mid_rst_arvalid", m_axi_arvalid, 0);
        check("mid_rst_bus_err", bus_err, 0);
        reset = 1;
        step;
        ic_fill(64'h8000, 64'h800);
        check("post_rst_bus_err", bus_err, 0);

        step; step;
        check("ar_queue_drained", exp_ar.size(), 0);
        check("beat_queue_drained", exp_beat.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_rd_arbiter.md
# mem_rd_arbiter

Read-channel arbiter that shares the single AXI read port between the instruction-cache fill path and the data-cache (`Dcache`) fill path. It sits between the two cache miss handlers and the top-level `m_axi_ar*`/`m_axi_r*` signals. It grants one requester at a time, issues one fixed-length INCR burst, and steers the returning beats to the granted requester. It also counts beats and flags protocol/response errors.

## Interface
- `ID_WIDTH`, 13, AXI ID width
- `ADDR_WIDTH`, 64, address width
- `DATA_WIDTH`, 64, data beat width
- `BURST_LEN`, 8, beats per fill burst (1..256); `arlen = BURST_LEN-1`
- `clk`  in  1  clock; all logic on rising edge
- `reset`  in  1  synchronous, active-low reset (asserted when 0)
- `ic_req_valid`  in  1  icache fill request; held with address until accepted
- `ic_req_addr`  in  ADDR_WIDTH  icache fill address, line-aligned
- `ic_req_ready`  out  1  one-cycle pulse: icache request accepted (AR handshake done)
- `ic_rvalid`  out  1  data beat valid for icache
- `ic_rlast`  out  1  final beat for icache
- `dc_req_valid`, `dc_req_addr`, `dc_req_ready`, `dc_rvalid`, `dc_rlast`  same as `ic_*`, for dcache
- `rdata`  out  DATA_WIDTH  beat data, shared by both requesters (qualified by `*_rvalid`)
- `m_axi_arid`  out  ID_WIDTH  0 = icache, 1 = dcache (zero-extended)
- `m_axi_araddr`  out  ADDR_WIDTH  registered granted address
- `m_axi_arlen`  out  8  constant `BURST_LEN-1`
- `m_axi_arsize`  out  3  constant `$clog2(DATA_WIDTH/8)` (3 for 64-bit)
- `m_axi_arburst`  out  2  constant 2'b01 (INCR)
- `m_axi_arvalid`  out  1  address valid
- `m_axi_arready`  in  1  address accepted
- `m_axi_rid`  in  ID_WIDTH  must equal the issued ID
- `m_axi_rdata`  in  DATA_WIDTH  beat data
- `m_axi_rresp`  in  2  response; nonzero is an error
- `m_axi_rlast`  in  1  last beat
- `m_axi_rvalid`  in  1  beat valid
- `m_axi_rready`  out  1  beat accept
- `bus_err`  out  1  sticky error; cleared only by reset

## Operation
- FSM states: IDLE, ADDR, DATA.
- **IDLE**
  - If any `*_req_valid` is high: choose the grant, latch `araddr` and `grant`, go to ADDR.
  - Arbitration is round-robin on `last_grant`. With both requesters valid, the one not granted last wins. With one valid, it wins. `last_grant` resets to icache, so dcache wins the first tie.
- **ADDR**
  - `m_axi_arvalid` = 1. `araddr` and `arid` stay stable until `arready`.
  - On `arvalid & arready`: pulse the granted `*_req_ready`, clear the beat counter, update `last_grant`, go to DATA.
- **DATA**
  - `m_axi_rready` = 1.
  - Each `m_axi_rvalid` beat: `rdata = m_axi_rdata`. The granted `*_rvalid` = 1 combinationally; the other requester's stays 0. The counter increments.
  - On `rvalid & rlast`: granted `*_rlast` = 1, go to IDLE.
- **Error checks** (set `bus_err`, data still forwarded):
  - `rresp != 0` on any beat.
  - `rid` ≠ issued ID.
  - `rlast` on a beat with counter ≠ `BURST_LEN-1`.
  - Counter reaching `BURST_LEN` without `rlast`. The FSM stays in DATA until `rlast`; the counter saturates.
- A request that drops `valid` in IDLE before being granted is simply not served. Once latched, a request is completed regardless of the requester's `valid`.
- One burst outstanding at a time; no AR is issued in DATA.

## Timing
- **Reset values:** state IDLE; `m_axi_arvalid` 0; `m_axi_rready` 0; both `*_req_ready`, `*_rvalid`, `*_rlast` 0; `araddr` 0; `arid` 0; `bus_err` 0; `last_grant` icache.
- **AR latency:** request in IDLE at cycle N → `arvalid` at N+1.
  - With `arready` high at N+1: `*_req_ready` pulse at N+1, `rready` high from N+2.
- **Back-to-back:** the `rlast` beat at cycle M → IDLE at M+1 → next `arvalid` at M+2.
- **R path:** zero-latency combinational steering from `m_axi_r*` to requester outputs; `rready` is a registered state decode.
- **Simultaneous events:**
  - A new request arriving during DATA waits for IDLE.
  - A request from the just-served requester together with the other's → the other wins.
- **Reset mid-burst:** FSM returns to IDLE and `rready`/`arvalid` drop the next edge. Outstanding beats are dropped; the system reset also resets the interconnect.

## Test plan
- **Single icache fill.** `ic_req_valid=1`, `addr=0x1000`, `arready=1`, 8 beats with data 0..7 and `rlast` on beat 7 → `araddr=0x1000`, `arid=0`, `arlen=7`, `arburst=1`, `arsize=3`. `ic_req_ready` pulses once. `ic_rvalid` ×8 with `rdata` 0..7 and `ic_rlast` on the 8th. `dc_rvalid` stays 0. `bus_err=0`.
- **Tie after reset.** Both requesters valid (ic `0x2000`, dc `0x3000`) → dcache burst first (`arid=1`), then icache. `arvalid` for the second burst appears 2 cycles after the first `rlast`.
- **Round-robin fairness.** Both requesters held valid for 4 bursts → grant order dc, ic, dc, ic.
- **Backpressure.** `arready` low for 5 cycles → `arvalid` held. `araddr`/`arid` stay constant. `*_req_ready` pulses only in the `arready` cycle.
- **Errors.** Each case gives `bus_err=1`, which stays set and FSM returns to IDLE after `rlast`:
  - `rresp=2'b10` on beat 3.
  - `rlast` on beat 5 (early).
  - `rid=1` on an icache burst.
- **Reset mid-burst.** `reset=0` during beat 4 → next edge: IDLE, `rready=0`, `bus_err=0`. A new request after reset is served normally.
